fc_layer_sequencer: RTL

Drives the 4-lane MAC accumulator for one fully-connected MNIST layer. Per output neuron it:
- streams IN_WORDS packed 32-bit feature/weight words out of the feature and weight SRAMs;
- drains the MAC pipeline and samples the accumulated sum;
- adds the neuron bias, applies ReLU, requantizes to 8 bits and emits the output;
- flushes the accumulator.
After the last neuron it reports the argmax index (predicted digit).

---
 rtl/fc_layer_sequencer.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/fc_layer_sequencer.sv
// Sequences one fully-connected layer on a 4-lane MAC: streams feature/weight words, drains the MAC,
// then applies bias, ReLU and requantization per neuron and reports the argmax neuron.
module fc_layer_sequencer #(
    parameter int IN_WORDS    = 196,
    parameter int NUM_NEURONS = 10,
    parameter int MAC_LAT     = 2,
    parameter int FA_W        = 8,
    parameter int WA_W        = 11,
    parameter int SHIFT       = 8
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            start,
    output logic            busy,
    output logic            done,
    output logic [FA_W-1:0] fmem_addr,
    input  logic [31:0]     fmem_data,
    output logic [WA_W-1:0] wmem_addr,
    input  logic [31:0]     wmem_data,
    output logic [3:0]      bmem_addr,
    input  logic [8:0]      bmem_data,
    output logic            mac_en,
    output logic            mac_flush,
    output logic [31:0]     mac_feature,
    output logic [31:0]     mac_weight,
    input  logic [25:0]     mac_result,
    output logic            out_valid,
    output logic [3:0]      out_index,
    output logic [7:0]      out_data,
    output logic [3:0]      argmax_index
);
    localparam int DW = $clog2(MAC_LAT + 2);
    localparam logic signed [26:0] MOST_NEG = {1'b1, 26'd0};

    typedef enum logic [2:0] {
        S_IDLE,
        S_STREAM,
        S_DRAIN,
        S_POST,
        S_FLUSH,
        S_FINISH
    } state_t;

    state_t state, state_nxt;

    logic [FA_W-1:0]    word_cnt;
    logic [WA_W-1:0]    wptr;
    logic [3:0]         neuron_cnt;
    logic [DW-1:0]      drain_cnt;
    logic               rd_issue;
    logic               last_word, last_neuron;
    logic signed [26:0] bias_ext, sum, best_val;
    logic [26:0]        shifted;
    logic [7:0]         q;
    logic [3:0]         best_idx;

    // The counters double as the SRAM addresses; wptr runs across neurons so no multiply is needed.
    assign fmem_addr   = word_cnt;
    assign wmem_addr   = wptr;
    assign bmem_addr   = neuron_cnt;
    assign mac_feature = fmem_data;
    assign mac_weight  = wmem_data;
    assign last_word   = (word_cnt == FA_W'(IN_WORDS - 1));
    assign last_neuron = (neuron_cnt == 4'(NUM_NEURONS - 1));

    always_comb begin
        bias_ext = {{18{bmem_data[8]}}, bmem_data};
        sum      = $signed({1'b0, mac_result}) + bias_ext;
        shifted  = sum >>> SHIFT;
        if (sum[26])
            q = 8'd0;
        else if (shifted > 27'd255)
            q = 8'hFF;
        else
            q = shifted[7:0];
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        mac_flush = 1'b0;
        rd_issue  = 1'b0;
        case (state)
            S_IDLE:   if (start) state_nxt = S_STREAM;
            S_STREAM: begin
                busy     = 1'b1;
                rd_issue = 1'b1;
                if (last_word) state_nxt = S_DRAIN;
            end
            S_DRAIN: begin
                busy = 1'b1;
                if (drain_cnt == '0) state_nxt = S_POST;
            end
            S_POST: begin
                busy      = 1'b1;
                state_nxt = S_FLUSH;
            end
            S_FLUSH: begin
                busy      = 1'b1;
                mac_flush = 1'b1;
                state_nxt = last_neuron ? S_FINISH : S_STREAM;
            end
            S_FINISH: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default:  state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state        <= S_IDLE;
            word_cnt     <= '0;
            wptr         <= '0;
            neuron_cnt   <= '0;
            drain_cnt    <= '0;
            mac_en       <= 1'b0;
            out_valid    <= 1'b0;
            out_index    <= '0;
            out_data     <= '0;
            argmax_index <= '0;
            best_val     <= MOST_NEG;
            best_idx     <= '0;
        end else begin
            state     <= state_nxt;
            mac_en    <= rd_issue;
            out_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        word_cnt   <= '0;
                        wptr       <= '0;
                        neuron_cnt <= '0;
                        best_val   <= MOST_NEG;
                        best_idx   <= '0;
                    end
                end
                S_STREAM: begin
                    wptr      <= wptr + WA_W'(1);
                    drain_cnt <= DW'(MAC_LAT);
                    if (!last_word) word_cnt <= word_cnt + FA_W'(1);
                end
                S_DRAIN: begin
                    if (drain_cnt != '0) drain_cnt <= drain_cnt - DW'(1);
                end
                S_POST: begin
                    out_valid <= 1'b1;
                    out_data  <= q;
                    out_index <= neuron_cnt;
                    // Strict compare keeps the lower index on ties.
                    if (sum > best_val) begin
                        best_val <= sum;
                        best_idx <= neuron_cnt;
                    end
                end
                S_FLUSH: begin
                    if (last_neuron) begin
                        argmax_index <= best_idx;
                    end else begin
                        neuron_cnt <= neuron_cnt + 4'd1;
                        word_cnt   <= '0;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
